// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the LED matrix scanner and the frame-memory writer:
// scan FSM states and pixel-word field helpers.
package led_matrix_scan_pkg;

    // A pixel word holds two colour fields: red in the low half, green above it.
    localparam int unsigned PX_FIELDS = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW
    } scan_state_t;

    // Red brightness level of a pixel word.
    function automatic int unsigned px_red(input int unsigned word, input int unsigned lvl_bits);
        return word & ((32'd1 << lvl_bits) - 32'd1);
    endfunction

    // Green brightness level of a pixel word.
    function automatic int unsigned px_green(input int unsigned word, input int unsigned lvl_bits);
        return (word >> lvl_bits) & ((32'd1 << lvl_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/led_row_buffer.sv
// Shadow store for one matrix row plus per-column brightness comparators.
// The compare path forwards a same-cycle write so the row can be shown on the
// cycle its last pixel arrives.
module led_row_buffer
    import led_matrix_scan_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int LVL_BITS = 2,
    localparam int SW      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int WW      = PX_FIELDS * LVL_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SW-1:0]       wr_slot,
    input  logic [WW-1:0]       wr_word,
    input  logic [LVL_BITS-1:0] sub_idx,
    output logic [COLS-1:0]     r_cmp,
    output logic [COLS-1:0]     g_cmp
);

    logic [WW-1:0] slot [COLS];
    logic [WW-1:0] word;

    // Shadow slots: cleared by reset, written one pixel at a time during row load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < COLS; c++) slot[c] <= '0;
        end else if (wr_en) begin
            slot[wr_slot] <= wr_word;
        end
    end

    // Column lit when its level exceeds the current subframe index.
    always_comb begin
        word  = '0;
        r_cmp = '0;
        g_cmp = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            word     = (wr_en && (wr_slot == SW'(c))) ? wr_word : slot[c];
            r_cmp[c] = px_red(32'(word), LVL_BITS) > 32'(sub_idx);
            g_cmp[c] = px_green(32'(word), LVL_BITS) > 32'(sub_idx);
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed bicolour LED matrix driver with binary-weighted-free PWM:
// each row is loaded from frame memory into a shadow buffer, then shown for
// DWELL cycles; NSUB subframes per frame give 2^LVL_BITS brightness levels.
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int LVL_BITS = 2,
    parameter int DWELL    = 1562,
    localparam int AW      = $clog2(ROWS * COLS),
    localparam int NSUB    = (1 << LVL_BITS) - 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  enable,
    input  logic [2*LVL_BITS-1:0] data,
    output logic [AW-1:0]         address,
    output logic                  rd_en,
    output logic [ROWS-1:0]       row,
    output logic [COLS-1:0]       r_col,
    output logic [COLS-1:0]       g_col,
    output logic                  frame_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS + 1);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int SW = (COLS > 1) ? $clog2(COLS) : 1;

    scan_state_t         state;
    logic [RW-1:0]       row_idx;
    logic [CW-1:0]       col_idx;
    logic [LVL_BITS-1:0] sub_idx;
    logic [DW-1:0]       dwell_cnt;

    logic                buf_wr;
    logic [SW-1:0]       buf_slot;
    logic [COLS-1:0]     r_cmp;
    logic [COLS-1:0]     g_cmp;
    logic                last_row;
    logic                last_sub;
    logic [RW-1:0]       nxt_row;

    // Data returned for LOAD cycle k lands in slot k-1; the final slot arrives
    // on the LOAD->SHOW edge and reaches the columns through the buffer bypass.
    assign buf_wr   = (state == LOAD) && enable && (col_idx != '0);
    assign buf_slot = SW'(col_idx - CW'(1));
    assign last_row = (row_idx == RW'(ROWS - 1));
    assign last_sub = (sub_idx == LVL_BITS'(NSUB - 1));
    assign nxt_row  = last_row ? '0 : row_idx + RW'(1);

    led_row_buffer #(
        .COLS     (COLS),
        .LVL_BITS (LVL_BITS)
    ) u_row_buffer (
        .clk      (clk),
        .rst      (nrst),
        .wr_en    (buf_wr),
        .wr_slot  (buf_slot),
        .wr_word  (data),
        .sub_idx  (sub_idx),
        .r_cmp    (r_cmp),
        .g_cmp    (g_cmp)
    );

    // Scan FSM with registered read strobe, address, row and column drives.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state      <= IDLE;
            row_idx    <= '0;
            col_idx    <= '0;
            sub_idx    <= '0;
            dwell_cnt  <= '0;
            address    <= '0;
            rd_en      <= 1'b0;
            row        <= '1;
            r_col      <= '0;
            g_col      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= LOAD;
                        col_idx <= '0;
                        rd_en   <= 1'b1;
                        address <= AW'(32'(row_idx) * 32'(COLS));
                    end
                end
                LOAD: begin
                    if (!enable) begin
                        state     <= IDLE;
                        col_idx   <= '0;
                        dwell_cnt <= '0;
                        rd_en     <= 1'b0;
                        address   <= '0;
                    end else if (col_idx == CW'(COLS)) begin
                        state     <= SHOW;
                        dwell_cnt <= '0;
                        row       <= ~(ROWS'(1) << row_idx);
                        r_col     <= r_cmp;
                        g_col     <= g_cmp;
                    end else begin
                        col_idx <= col_idx + CW'(1);
                        if (col_idx < CW'(COLS - 1)) begin
                            rd_en   <= 1'b1;
                            address <= AW'(32'(row_idx) * 32'(COLS) + 32'(col_idx) + 32'd1);
                        end else begin
                            rd_en   <= 1'b0;
                            address <= '0;
                        end
                    end
                end
                SHOW: begin
                    if (dwell_cnt == DW'(DWELL - 1)) begin
                        // A completed row always advances, even if enable just
                        // dropped, so a frame-end pulse is never lost.
                        row_idx <= nxt_row;
                        if (last_row) begin
                            sub_idx    <= last_sub ? '0 : sub_idx + LVL_BITS'(1);
                            frame_done <= last_sub;
                        end
                        row       <= '1;
                        r_col     <= '0;
                        g_col     <= '0;
                        dwell_cnt <= '0;
                        col_idx   <= '0;
                        if (enable) begin
                            state   <= LOAD;
                            rd_en   <= 1'b1;
                            address <= AW'(32'(nxt_row) * 32'(COLS));
                        end else begin
                            state   <= IDLE;
                            rd_en   <= 1'b0;
                            address <= '0;
                        end
                    end else if (!enable) begin
                        state     <= IDLE;
                        dwell_cnt <= '0;
                        col_idx   <= '0;
                        row       <= '1;
                        r_col     <= '0;
                        g_col     <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: a row-period/phase reference model
// predicts every output each cycle; directed scenarios add frame-level counts.
module tb_led_matrix_scan;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int LB    = 2;
    localparam int DWELL = 4;
    localparam int NSUB  = (1 << LB) - 1;
    localparam int RP    = COLS + 1 + DWELL;
    localparam int FRAME = NSUB * ROWS * RP;
    localparam int AW    = $clog2(ROWS * COLS);

    logic            clk = 1'b0;
    logic            nrst = 1'b1;
    logic            enable = 1'b0;
    logic [2*LB-1:0] data = '0;
    logic [AW-1:0]   address;
    logic            rd_en;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] r_col;
    logic [COLS-1:0] g_col;
    logic            frame_done;

    logic [2*LB-1:0] mem [ROWS*COLS];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running flag, phase within row period, row, subframe.
    bit m_run = 0;
    int m_t = 0;
    int m_r = 0;
    int m_s = 0;
    bit m_fd = 0;

    led_matrix_scan #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .LVL_BITS (LB),
        .DWELL    (DWELL)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .data       (data),
        .address    (address),
        .rd_en      (rd_en),
        .row        (row),
        .r_col      (r_col),
        .g_col      (g_col),
        .frame_done (frame_done)
    );

    always #10 clk = ~clk;

    // Frame memory with one-cycle read latency.
    always @(posedge clk) data <= mem[address];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_r = 0; m_s = 0; m_fd = 0;
    endtask

    task automatic model_edge(input bit en, input bit rst);
        m_fd = 0;
        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            if (en) begin m_run = 1; m_t = 0; end
        end else if (m_t == RP - 1) begin
            m_r = m_r + 1;
            if (m_r == ROWS) begin
                m_r = 0;
                m_s = m_s + 1;
                if (m_s == NSUB) begin m_s = 0; m_fd = 1; end
            end
            m_t = 0;
            m_run = en;
        end else if (!en) begin
            m_run = 0; m_t = 0;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    task automatic compare_all();
        logic            e_rd;
        logic [AW-1:0]   e_addr;
        logic [ROWS-1:0] e_row;
        logic [COLS-1:0] e_r;
        logic [COLS-1:0] e_g;
        int lv;
        e_rd = 0; e_addr = '0; e_row = '1; e_r = '0; e_g = '0;
        if (m_run && m_t < COLS) begin
            e_rd = 1;
            e_addr = AW'(m_r * COLS + m_t);
        end
        if (m_run && m_t > COLS) begin
            e_row = ~(ROWS'(1) << m_r);
            for (int c = 0; c < COLS; c++) begin
                lv = int'(mem[m_r * COLS + c]);
                e_r[c] = (lv % (1 << LB)) > m_s;
                e_g[c] = (lv / (1 << LB)) > m_s;
            end
        end
        check_eq("rd_en", 32'(rd_en), 32'(e_rd));
        check_eq("address", 32'(address), 32'(e_addr));
        check_eq("row", 32'(row), 32'(e_row));
        check_eq("r_col", 32'(r_col), 32'(e_r));
        check_eq("g_col", 32'(g_col), 32'(e_g));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(enable, nrst);
        #1;
        compare_all();
    endtask

    // Hold reset for two edges with memory loaded by the caller afterwards.
    task automatic sync_reset();
        enable = 0;
        nrst = 1;
        model_reset();
        tick();
        tick();
        nrst = 0;
    endtask

    task automatic async_reset();
        #4;
        nrst = 1;
        model_reset();
        #1;
        compare_all();
        check_eq("async_blank_row", 32'(row), 32'(8'hFF));
        tick();
        nrst = 0;
    endtask

    task automatic fill_mem(input int val);
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = (2*LB)'(val);
    endtask

    task automatic run_to_frame_done(input string tag);
        int found;
        found = -1;
        for (int i = 0; i < FRAME + 40; i++) begin
            tick();
            if (frame_done) begin found = i; break; end
        end
        check_eq(tag, 32'(found), 32'(FRAME));
    endtask

    task automatic count_row2(output int n_r, output int n_g, output int n_rg, output int n_any);
        n_r = 0; n_g = 0; n_rg = 0; n_any = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (row == 8'hFB) begin
                if (r_col == 8'h20) n_r++;
                if (g_col == 8'h20) n_g++;
                if (r_col == 8'h20 && g_col == 8'h20) n_rg++;
                if ((r_col | g_col) != 0) n_any++;
            end
        end
    endtask

    initial begin
        int n_r, n_g, n_rg, n_any;
        int found;
        int off_left;

        fill_mem(0);

        // Blank frame: all-zero pixels, frame period.
        sync_reset();
        compare_all();
        check_eq("reset_rd_en", 32'(rd_en), 32'(0));
        check_eq("reset_row", 32'(row), 32'(8'hFF));
        enable = 1;
        run_to_frame_done("frame_period_blank");

        // Single red pixel at full and at lowest level.
        sync_reset();
        fill_mem(0);
        mem[2*COLS+5] = 4'b0011;
        enable = 1;
        count_row2(n_r, n_g, n_rg, n_any);
        check_eq("red3_lit_cycles", 32'(n_r), 32'(NSUB * DWELL));
        check_eq("red3_green_off", 32'(n_g), 32'(0));

        sync_reset();
        mem[2*COLS+5] = 4'b0001;
        enable = 1;
        count_row2(n_r, n_g, n_rg, n_any);
        check_eq("red1_lit_cycles", 32'(n_r), 32'(DWELL));

        // Mixed red 2 + green 2: coincident in subframes 0 and 1 only.
        sync_reset();
        mem[2*COLS+5] = 4'b1010;
        enable = 1;
        count_row2(n_r, n_g, n_rg, n_any);
        check_eq("yellow_both_cycles", 32'(n_rg), 32'(2 * DWELL));
        check_eq("yellow_any_cycles", 32'(n_any), 32'(2 * DWELL));

        // Pause mid-SHOW of row 4, then resume.
        sync_reset();
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = (2*LB)'($urandom);
        enable = 1;
        found = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (m_run && m_r == 4 && m_t == COLS + 2) begin found = 1; break; end
        end
        check_eq("reach_row4_show", 32'(found), 32'(1));
        enable = 0;
        tick();
        check_eq("pause_blank_row", 32'(row), 32'(8'hFF));
        check_eq("pause_blank_r", 32'(r_col), 32'(0));
        for (int i = 0; i < 9; i++) tick();
        enable = 1;
        tick();
        check_eq("resume_addr", 32'(address), 32'(32));
        check_eq("resume_rd_en", 32'(rd_en), 32'(1));
        for (int i = 0; i < 3 * RP; i++) tick();

        // Asynchronous reset mid-LOAD of row 6.
        found = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (m_run && m_r == 6 && m_t == 3) begin found = 1; break; end
        end
        check_eq("reach_row6_load", 32'(found), 32'(1));
        async_reset();
        tick();
        check_eq("restart_addr", 32'(address), 32'(0));
        check_eq("restart_rd_en", 32'(rd_en), 32'(1));
        // Frame count from the first LOAD cycle just observed.
        found = -1;
        for (int i = 1; i < FRAME + 40; i++) begin
            tick();
            if (frame_done) begin found = i; break; end
        end
        check_eq("frame_period_after_reset", 32'(found), 32'(FRAME));

        // Random pauses, memory updates while idle, occasional resets.
        off_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (enable && $urandom_range(0, 39) == 0) begin
                enable = 0;
                off_left = $urandom_range(1, 15);
            end else if (!enable) begin
                off_left--;
                if (off_left <= 0) enable = 1;
            end
            if (!m_run) begin
                for (int k = 0; k < 4; k++) mem[$urandom_range(0, ROWS*COLS-1)] = (2*LB)'($urandom);
            end
            if ($urandom_range(0, 599) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
